// File: rtl/uart_pkg.sv
// Shared definitions for the UART command parser: FSM state codes, error codes
// and the default start-of-packet byte.
package uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_LENGTH  = 3'd2;
  localparam logic [2:0] ERR_CSUM    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage

// File: rtl/uart_byte_fetch.sv
// Accept/flush handshake with the UART receiver. A byte is taken once, then a
// guard blocks re-acceptance until the receiver drops rx_converted.
module uart_byte_fetch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_converted,
  input  logic       rx_data_valid,
  output logic       flush,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       byte_ok
);

  logic guard;

  assign byte_stb = rx_converted && !guard;
  assign rx_byte  = rx_data;
  assign byte_ok  = rx_data_valid;

  // The receiver keeps converted high for a couple of cycles after flush, so
  // the guard only releases once it has actually gone low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      guard <= 1'b0;
      flush <= 1'b0;
    end else begin
      flush <= byte_stb;
      if (byte_stb)
        guard <= 1'b1;
      else if (!rx_converted)
        guard <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Packet parser: header, cmd, len, payload, checksum. Optional inter-byte
// timeout enabled by defining UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 500000,
  localparam int        AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_converted,
  input  logic          rx_data_valid,
  output logic          flush,
  output logic          busy,
  output logic [7:0]    cmd,
  output logic [7:0]    len,
  output logic          pl_we,
  output logic [AW-1:0] pl_waddr,
  output logic [7:0]    pl_wdata,
  output logic          pkt_done,
  output logic          pkt_err,
  output logic [2:0]    err_code
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  logic       byte_stb;
  logic       byte_ok;
  logic [7:0] rx_byte;
  logic [2:0] state;
  logic [7:0] acc;
  logic [7:0] idx;
  logic       tmo_hit;

  uart_byte_fetch u_fetch (
    .clk           (i_clk),
    .rst_n         (i_rst_n),
    .rx_data       (rx_data),
    .rx_converted  (rx_converted),
    .rx_data_valid (rx_data_valid),
    .flush         (flush),
    .byte_stb      (byte_stb),
    .rx_byte       (rx_byte),
    .byte_ok       (byte_ok)
  );

  assign busy = (state != ST_HUNT);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      tmo_cnt <= '0;
    else if (byte_stb || state == ST_HUNT)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = busy && !byte_stb && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // A parity-bad byte aborts any packet in progress; in HUNT it is just dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_HUNT;
      acc      <= 8'd0;
      idx      <= 8'd0;
      cmd      <= 8'd0;
      len      <= 8'd0;
      pl_we    <= 1'b0;
      pl_waddr <= '0;
      pl_wdata <= 8'd0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      pl_we    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      if (byte_stb) begin
        if (state != ST_HUNT && !byte_ok) begin
          pkt_err  <= 1'b1;
          err_code <= ERR_PARITY;
          state    <= ST_HUNT;
        end else begin
          case (state)
            ST_HUNT: begin
              if (byte_ok && rx_byte == HEADER) begin
                acc   <= 8'd0;
                state <= ST_CMD;
              end
            end
            ST_CMD: begin
              cmd   <= rx_byte;
              acc   <= rx_byte;
              state <= ST_LEN;
            end
            ST_LEN: begin
              if (rx_byte > MAX_LEN) begin
                pkt_err  <= 1'b1;
                err_code <= ERR_LENGTH;
                state    <= ST_HUNT;
              end else begin
                len   <= rx_byte;
                acc   <= acc + rx_byte;
                idx   <= 8'd0;
                state <= (rx_byte == 8'd0) ? ST_CSUM : ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              pl_we    <= 1'b1;
              pl_waddr <= idx[AW-1:0];
              pl_wdata <= rx_byte;
              acc      <= acc + rx_byte;
              idx      <= idx + 8'd1;
              if (idx == len - 8'd1)
                state <= ST_CSUM;
            end
            ST_CSUM: begin
              if (rx_byte == acc) begin
                pkt_done <= 1'b1;
              end else begin
                pkt_err  <= 1'b1;
                err_code <= ERR_CSUM;
              end
              state <= ST_HUNT;
            end
            default: state <= ST_HUNT;
          endcase
        end
      end else if (tmo_hit) begin
        pkt_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= ST_HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a small receiver model feeds packets and
// event counters observed on the falling edge are compared with hand values.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_converted = 1'b0;
  logic       rx_data_valid = 1'b1;
  logic       flush, busy, pl_we, pkt_done, pkt_err;
  logic [7:0] cmd, len, pl_wdata;
  logic [3:0] pl_waddr;
  logic [2:0] err_code;

  int total = 0;
  int bad = 0;

  int flush_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int b_flush, b_we, b_done, b_err;
  logic [3:0] wr_addr [64];
  logic [7:0] wr_data [64];
  logic [7:0] pkt [$];

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .MAX_PAYLOAD    (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .rx_data       (rx_data),
    .rx_converted  (rx_converted),
    .rx_data_valid (rx_data_valid),
    .flush         (flush),
    .busy          (busy),
    .cmd           (cmd),
    .len           (len),
    .pl_we         (pl_we),
    .pl_waddr      (pl_waddr),
    .pl_wdata      (pl_wdata),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .err_code      (err_code)
  );

  // Every cycle a pulse is high counts once, so a stuck pulse inflates the totals.
  always @(negedge clk) begin
    if (flush) flush_cnt++;
    if (pkt_done) done_cnt++;
    if (pkt_err) err_cnt++;
    if (pl_we) begin
      if (we_cnt < 64) begin
        wr_addr[we_cnt] = pl_waddr;
        wr_data[we_cnt] = pl_wdata;
      end
      we_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: present a byte, wait for flush, hold converted a few more cycles.
  task automatic applyStimulus(input logic [7:0] d, input logic v, input int hold);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    rx_data = d;
    rx_data_valid = v;
    rx_converted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (flush) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("flush_seen", 32'(seen), 32'd1);
    repeat (hold) @(negedge clk);
    rx_converted = 1'b0;
    rx_data_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic sendPkt();
    foreach (pkt[i]) applyStimulus(pkt[i], 1'b1, 2);
    repeat (2) @(negedge clk);
  endtask

  task automatic snap();
    b_flush = flush_cnt;
    b_we = we_cnt;
    b_done = done_cnt;
    b_err = err_cnt;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_cmd_len", {16'd0, cmd, len}, 32'd0);
    checkOutput("rst_pulses", {29'd0, pl_we, pkt_done, pkt_err}, 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte payload packet, checksum 01+02+10+20 = 33
    snap();
    pkt = {8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    sendPkt();
    checkOutput("p1_flushes", 32'(flush_cnt - b_flush), 32'd6);
    checkOutput("p1_writes", 32'(we_cnt - b_we), 32'd2);
    checkOutput("p1_w0", {20'd0, wr_addr[b_we], wr_data[b_we]}, {20'd0, 4'd0, 8'h10});
    checkOutput("p1_w1", {20'd0, wr_addr[b_we+1], wr_data[b_we+1]}, {20'd0, 4'd1, 8'h20});
    checkOutput("p1_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p1_err", 32'(err_cnt - b_err), 32'd0);
    checkOutput("p1_cmd_len", {16'd0, cmd, len}, {16'd0, 8'h01, 8'h02});
    checkOutput("p1_busy", 32'(busy), 32'd0);

    // Leading junk byte dropped, zero-length packet
    snap();
    pkt = {8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
    sendPkt();
    checkOutput("p2_flushes", 32'(flush_cnt - b_flush), 32'd5);
    checkOutput("p2_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p2_err", 32'(err_cnt - b_err), 32'd0);
    checkOutput("p2_writes", 32'(we_cnt - b_we), 32'd0);
    checkOutput("p2_cmd_len", {16'd0, cmd, len}, {16'd0, 8'h07, 8'h00});

    // Length 17 exceeds the maximum, then a good packet recovers
    snap();
    pkt = {8'hAA, 8'h01, 8'h11};
    sendPkt();
    checkOutput("p3_err", 32'(err_cnt - b_err), 32'd1);
    checkOutput("p3_err_code", 32'(err_code), 32'd2);
    checkOutput("p3_busy", 32'(busy), 32'd0);
    checkOutput("p3_len_kept", 32'(len), 32'd0);
    snap();
    pkt = {8'hAA, 8'h01, 8'h00, 8'h01};
    sendPkt();
    checkOutput("p3b_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p3b_err", 32'(err_cnt - b_err), 32'd0);

    // Bad checksum: 01+01+10 = 12, not FF
    snap();
    pkt = {8'hAA, 8'h01, 8'h01, 8'h10, 8'hFF};
    sendPkt();
    checkOutput("p4_err", 32'(err_cnt - b_err), 32'd1);
    checkOutput("p4_err_code", 32'(err_code), 32'd3);
    checkOutput("p4_done", 32'(done_cnt - b_done), 32'd0);
    checkOutput("p4_write", {20'd0, wr_addr[b_we], wr_data[b_we]}, {20'd0, 4'd0, 8'h10});

    // Header value used as payload data: 01+01+AA = AC
    snap();
    pkt = {8'hAA, 8'h01, 8'h01, 8'hAA, 8'hAC};
    sendPkt();
    checkOutput("p5_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p5_wdata", 32'(wr_data[b_we]), 32'hAA);

    // Maximum length 16, payload 00..0F: 03+10+78 = 8B
    snap();
    pkt = {8'hAA, 8'h03, 8'h10};
    for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
    pkt.push_back(8'h8B);
    sendPkt();
    checkOutput("p6_writes", 32'(we_cnt - b_we), 32'd16);
    checkOutput("p6_last", {20'd0, wr_addr[b_we+15], wr_data[b_we+15]}, {20'd0, 4'd15, 8'h0F});
    checkOutput("p6_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p6_len", 32'(len), 32'h10);

    // Parity error on cmd byte, converted held 3 cycles after flush
    snap();
    applyStimulus(8'hAA, 1'b1, 2);
    applyStimulus(8'h01, 1'b0, 3);
    repeat (2) @(negedge clk);
    checkOutput("p7_flushes", 32'(flush_cnt - b_flush), 32'd2);
    checkOutput("p7_err", 32'(err_cnt - b_err), 32'd1);
    checkOutput("p7_err_code", 32'(err_code), 32'd1);
    checkOutput("p7_busy", 32'(busy), 32'd0);

    // Reset in the middle of a payload discards the packet silently
    snap();
    pkt = {8'hAA, 8'h02, 8'h03, 8'h11};
    sendPkt();
    checkOutput("p8_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("p8_busy", 32'(busy), 32'd0);
    checkOutput("p8_cmd_len", {16'd0, cmd, len}, 32'd0);
    checkOutput("p8_outs", {20'd0, pl_waddr, pl_wdata}, 32'd0);
    checkOutput("p8_err_code", 32'(err_code), 32'd0);
    checkOutput("p8_err", 32'(err_cnt - b_err), 32'd0);
    rst_n = 1'b1;
    snap();
    pkt = {8'hAA, 8'h05, 8'h00, 8'h05};
    sendPkt();
    checkOutput("p8b_done", 32'(done_cnt - b_done), 32'd1);

    // Stall after the len byte
    snap();
    pkt = {8'hAA, 8'h04, 8'h01};
    sendPkt();
    repeat (100) @(negedge clk);
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    checkOutput("p9_err", 32'(err_cnt - b_err), 32'd1);
    checkOutput("p9_err_code", 32'(err_code), 32'd4);
    checkOutput("p9_busy", 32'(busy), 32'd0);
`else
    checkOutput("p9_err", 32'(err_cnt - b_err), 32'd0);
    checkOutput("p9_busy", 32'(busy), 32'd1);
    pkt = {8'h55, 8'h5A};
    sendPkt();
    checkOutput("p9_done", 32'(done_cnt - b_done), 32'd1);
    checkOutput("p9_wdata", 32'(wr_data[b_we]), 32'h55);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Packet-level stage directly downstream of the UART receiver in the alarm system.
- Consumes the receiver's byte/converted/data_valid outputs and returns its flush strobe, one byte at a time.
- Assembles framed command packets: header, cmd, len, payload, checksum.
- Writes payload bytes to an external buffer and pulses done or error per packet, for the alarm controller.

Parameters:
HEADER, 8'hAA, start-of-packet byte
MAX_PAYLOAD, 16, maximum legal len value (1..255)
AW, $clog2(MAX_PAYLOAD), payload address width (derived, not overridden)
TIMEOUT_CYCLES, 500000, inter-byte timeout in i_clk cycles (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
rx_data  in  8  byte from receiver; valid while rx_converted=1
rx_converted  in  1  receiver holds a byte; stays high until flushed
rx_data_valid  in  1  receiver parity result for rx_data
flush  out  1  one-cycle pulse releasing the receiver's byte
busy  out  1  high while in any state other than HUNT
cmd  out  8  command byte of the current/last packet
len  out  8  length byte of the current/last packet
pl_we  out  1  payload write strobe
pl_waddr  out  AW  payload write address, 0-based
pl_wdata  out  8  payload write data
pkt_done  out  1  one-cycle pulse: packet good
pkt_err  out  1  one-cycle pulse: packet aborted
err_code  out  3  1 parity, 2 length, 3 checksum, 4 timeout; held until next pkt_err

Behaviour:
- Reset (i_rst_n=0 at posedge): state HUNT; guard clear; all outputs 0. Applies mid-packet: the partial packet is discarded with no pkt_err.
- Accept condition: rx_converted=1 and guard clear.
  - On acceptance: flush=1 on the next cycle; guard set.
  - Guard clears on the first cycle rx_converted=0. The receiver drops converted about 2 cycles after flush, so no byte is consumed twice.
- States and transitions on acceptance:
  - HUNT: byte==HEADER goes to CMD and clears the checksum accumulator. Any other byte, or a parity-bad byte, is flushed and dropped silently with no pkt_err.
  - CMD: cmd<=byte; acc<=byte; go to LEN.
  - LEN:
    - byte>MAX_PAYLOAD: pkt_err, err_code=2, go to HUNT.
    - Otherwise len<=byte; acc+=byte; idx<=0.
    - byte==0 goes to CSUM; else go to PAYLOAD.
  - PAYLOAD: pl_we=1, pl_waddr=idx, pl_wdata=byte (registered, same cycle as flush); acc+=byte; idx++. After byte len-1, go to CSUM.
  - CSUM: byte==acc gives pkt_done; else pkt_err with err_code=3. Either way go to HUNT.
- Checksum: 8-bit sum mod 256 of cmd, len and payload. Header excluded.
- Parity: rx_data_valid=0 on an accepted byte in CMD/LEN/PAYLOAD/CSUM gives pkt_err, err_code=4'd1 (value 1), then HUNT. The byte is still flushed.
- HEADER value inside a packet is ordinary data; no resynchronisation.
- Output timing: pkt_done, pkt_err and pl_we are single-cycle, asserted the cycle after acceptance, coincident with flush. cmd and len hold until overwritten by the next packet.

Optional Feature:
Macro UART_CMD_PARSER_TIMEOUT_EN.
- Defined: a counter clears on every acceptance and on entering HUNT, and counts while busy. Reaching TIMEOUT_CYCLES-1 gives pkt_err, err_code=4, then HUNT.
- Undefined: no counter is instantiated; err_code 4 is never produced; a stalled packet waits indefinitely.

Decomposition:
- Shared package uart_pkg: state enum (HUNT, CMD, LEN, PAYLOAD, CSUM), err_code constants, HEADER default.
- Sub-module uart_byte_fetch: accept/flush/guard handshake. It outputs byte_stb, byte and byte_ok to the parser FSM.

Test Plan:
- Send AA 01 02 10 20 33 -> pl_we at addr 0=0x10, addr 1=0x20; pkt_done once; cmd=0x01, len=0x02; exactly 6 flush pulses.
- Send 55 AA 07 00 07 -> 0x55 dropped silently; pkt_done; no pl_we; len=0.
- Send AA 01 11 (MAX_PAYLOAD=16) -> pkt_err, err_code=2; the following AA 01 00 01 gives pkt_done.
- Send AA 01 01 10 FF -> pkt_err, err_code=3.
- Send AA 01 with rx_data_valid=0 on 0x01 -> pkt_err, err_code=1, state HUNT. Hold rx_converted high 3 cycles after flush -> still exactly one acceptance.
- Assert i_rst_n=0 mid-payload -> all outputs 0, busy=0, no pkt_err. With the macro defined, stall 500000 cycles after the len byte -> pkt_err, err_code=4.
